// File: rtl/des_l1_responder_pkg.sv
// Shared types and constants for the des_l1_responder AXI4 L1 stand-in.
package des_l1_responder_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_SIZE_W = 3;
    localparam int unsigned AXI_RESP_W = 2;
    localparam int unsigned STAT_W     = 32;

    localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_32B = 3'b010;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [1:0] {
        L1_IDLE,
        L1_WR_ACCEPT,
        L1_WR_RESP,
        L1_RD_BURST
    } l1_resp_state_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/des_l1_responder_if.sv
// AXI4 l1 port bundle; slave modport is the responder side, master the core side.
interface des_l1_responder_if;
    import des_l1_responder_pkg::*;

    logic                  ARVALID;
    logic                  ARREADY;
    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [AXI_LEN_W-1:0]  ARLEN;
    logic [AXI_SIZE_W-1:0] ARSIZE;
    logic                  RVALID;
    logic                  RREADY;
    logic [AXI_DATA_W-1:0] RDATA;
    logic                  RLAST;
    logic                  RID;
    logic [AXI_RESP_W-1:0] RRESP;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [AXI_ADDR_W-1:0] AWADDR;
    logic [AXI_LEN_W-1:0]  AWLEN;
    logic [AXI_SIZE_W-1:0] AWSIZE;
    logic                  WVALID;
    logic                  WREADY;
    logic [AXI_DATA_W-1:0] WDATA;
    logic [AXI_STRB_W-1:0] WSTRB;
    logic                  WLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic [AXI_RESP_W-1:0] BRESP;
    logic                  BID;

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARSIZE, RREADY,
        input  AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
        output ARREADY, RVALID, RDATA, RLAST, RID, RRESP,
        output AWREADY, WREADY, BVALID, BRESP, BID
    );

    modport master (
        output ARVALID, ARADDR, ARLEN, ARSIZE, RREADY,
        output AWVALID, AWADDR, AWLEN, AWSIZE, WVALID, WDATA, WSTRB, WLAST, BREADY,
        input  ARREADY, RVALID, RDATA, RLAST, RID, RRESP,
        input  AWREADY, WREADY, BVALID, BRESP, BID
    );

endinterface

// File: rtl/des_l1_responder_l1_ram.sv
// Simple dual-port byte-enable RAM: one write port, one read port with RD_LAT registered stages.
// en_i advances the whole read pipeline; rd_zero_i forces the beat entering it to read as zero.
module des_l1_responder_l1_ram
    import des_l1_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    input  logic [AXI_STRB_W-1:0] wstrb_i,
    input  logic                  en_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    input  logic                  rd_zero_i,
    output logic [AXI_DATA_W-1:0] rdata_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [AXI_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(AXI_STRB_W); b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        logic [AXI_DATA_W-1:0] rdata_q;
        always_ff @(posedge clk_i) begin
            if (rst_i)     rdata_q <= '0;
            else if (en_i) rdata_q <= rd_zero_i ? '0 : mem_q[raddr_i];
        end
        assign rdata_o = rdata_q;
    end else begin : g_lat2
        logic [AXI_DATA_W-1:0] s1_q;
        logic [AXI_DATA_W-1:0] rdata_q;
        logic                  zero1_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_q    <= '0;
                zero1_q <= 1'b1;
                rdata_q <= '0;
            end else if (en_i) begin
                s1_q    <= mem_q[raddr_i];
                zero1_q <= rd_zero_i;
                rdata_q <= zero1_q ? '0 : s1_q;
            end
        end
        assign rdata_o = rdata_q;
    end

endmodule

// File: rtl/des_l1_responder.sv
// AXI4 responder for a core's 32-bit l1 port, backed by on-chip RAM.
// Optional statistics counters are built when L1_STATS_EN is defined.
module des_l1_responder
    import des_l1_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    des_l1_responder_if.slave s_axi_l1_V,
    output logic [STAT_W-1:0] stat_rd_beats,
    output logic [STAT_W-1:0] stat_wr,
    output logic [STAT_W-1:0] stat_err
);
    // Word index carries one extra bit so a burst running past 2**32 stays out of range.
    localparam int unsigned WORD_W   = AXI_ADDR_W - 1;
    localparam int unsigned PIPE_TOP = RD_LAT - 1;

    l1_resp_state_t        state_q;
    logic                  arready_q, awready_q, wready_q, bvalid_q;
    axi_resp_t             bresp_q;
    logic                  aw_got_q, w_got_q;
    logic [AXI_ADDR_W-1:0] awaddr_q;
    logic [AXI_LEN_W-1:0]  awlen_q;
    logic [AXI_SIZE_W-1:0] awsize_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic [AXI_LEN_W-1:0]  arlen_q;
    logic                  size_bad_q;
    logic                  issuing_q;
    logic [AXI_LEN_W-1:0]  iss_idx_q;
    logic [WORD_W-1:0]     nxt_word_q;
    logic [RD_LAT-1:0]     vld_q, last_q, err_q;

    logic              ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic              rd_adv, iss, iss_last, iss_err, iss_size_bad;
    logic              wr_both, wr_err, ram_we;
    logic [WORD_W-1:0] iss_word;

    // Handshakes, read-beat issue and write error decode.
    always_comb begin
        ar_hs        = (state_q == L1_RD_BURST) && arready_q && s_axi_l1_V.ARVALID;
        aw_hs        = awready_q && s_axi_l1_V.AWVALID;
        w_hs         = wready_q && s_axi_l1_V.WVALID;
        r_hs         = vld_q[PIPE_TOP] && s_axi_l1_V.RREADY;
        b_hs         = bvalid_q && s_axi_l1_V.BREADY;
        rd_adv       = !vld_q[PIPE_TOP] || s_axi_l1_V.RREADY;
        iss_word     = ar_hs ? {1'b0, s_axi_l1_V.ARADDR[AXI_ADDR_W-1:2]} : nxt_word_q;
        iss_size_bad = ar_hs ? (s_axi_l1_V.ARSIZE != AXI_SIZE_32B) : size_bad_q;
        iss_last     = ar_hs ? (s_axi_l1_V.ARLEN == '0) : (iss_idx_q == arlen_q);
        iss_err      = iss_size_bad || (|iss_word[WORD_W-1:DEPTH_LOG2]);
        iss          = rd_adv && (ar_hs || ((state_q == L1_RD_BURST) && issuing_q));
        wr_both      = (state_q == L1_WR_ACCEPT) && aw_got_q && w_got_q;
        wr_err       = (awlen_q != '0) || (awsize_q != AXI_SIZE_32B)
                    || (|awaddr_q[AXI_ADDR_W-1:DEPTH_LOG2+2]);
        ram_we       = wr_both && !wr_err;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= L1_IDLE;
            arready_q  <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            arlen_q    <= '0;
            size_bad_q <= 1'b0;
            issuing_q  <= 1'b0;
            iss_idx_q  <= '0;
            nxt_word_q <= '0;
        end else begin
            unique case (state_q)
                L1_IDLE: begin
                    if (s_axi_l1_V.AWVALID) begin
                        state_q   <= L1_WR_ACCEPT;
                        awready_q <= 1'b1;
                        wready_q  <= s_axi_l1_V.WVALID;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                    end else if (s_axi_l1_V.ARVALID) begin
                        state_q   <= L1_RD_BURST;
                        arready_q <= 1'b1;
                    end
                end
                L1_WR_ACCEPT: begin
                    if (aw_hs) begin
                        awaddr_q <= s_axi_l1_V.AWADDR;
                        awlen_q  <= s_axi_l1_V.AWLEN;
                        awsize_q <= s_axi_l1_V.AWSIZE;
                        aw_got_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= s_axi_l1_V.WDATA;
                        wstrb_q <= s_axi_l1_V.WSTRB;
                        w_got_q <= 1'b1;
                    end
                    awready_q <= !(aw_got_q || aw_hs) && s_axi_l1_V.AWVALID;
                    wready_q  <= !(w_got_q || w_hs) && s_axi_l1_V.WVALID;
                    if (wr_both) begin
                        state_q  <= L1_WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_err ? SLVERR : OKAY;
                    end
                end
                L1_WR_RESP: begin
                    if (b_hs) begin
                        bvalid_q <= 1'b0;
                        state_q  <= L1_IDLE;
                    end
                end
                L1_RD_BURST: begin
                    if (ar_hs) begin
                        arready_q  <= 1'b0;
                        arlen_q    <= s_axi_l1_V.ARLEN;
                        size_bad_q <= iss_size_bad;
                    end
                    if (iss) begin
                        nxt_word_q <= iss_word + WORD_W'(1);
                        iss_idx_q  <= ar_hs ? AXI_LEN_W'(1) : iss_idx_q + AXI_LEN_W'(1);
                        issuing_q  <= !iss_last;
                    end
                    if (r_hs && last_q[PIPE_TOP]) state_q <= L1_IDLE;
                end
                default: state_q <= L1_IDLE;
            endcase
        end
    end

    // Beat sideband pipeline, advancing in lockstep with the RAM read stages.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            vld_q  <= '0;
            last_q <= '0;
            err_q  <= '0;
        end else if (rd_adv) begin
            vld_q[0]  <= iss;
            last_q[0] <= iss && iss_last;
            err_q[0]  <= iss && iss_err;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                err_q[i]  <= err_q[i-1];
            end
        end
    end

    des_l1_responder_l1_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT)
    ) u_ram (
        .clk_i     (ap_clk),
        .rst_i     (ap_rst),
        .we_i      (ram_we),
        .waddr_i   (awaddr_q[DEPTH_LOG2+1:2]),
        .wdata_i   (wdata_q),
        .wstrb_i   (wstrb_q),
        .en_i      (rd_adv),
        .raddr_i   (iss_word[DEPTH_LOG2-1:0]),
        .rd_zero_i (!iss || iss_err),
        .rdata_o   (s_axi_l1_V.RDATA)
    );

    assign s_axi_l1_V.ARREADY = arready_q;
    assign s_axi_l1_V.AWREADY = awready_q;
    assign s_axi_l1_V.WREADY  = wready_q;
    assign s_axi_l1_V.RVALID  = vld_q[PIPE_TOP];
    assign s_axi_l1_V.RLAST   = last_q[PIPE_TOP];
    assign s_axi_l1_V.RRESP   = err_q[PIPE_TOP] ? SLVERR : OKAY;
    assign s_axi_l1_V.RID     = 1'b0;
    assign s_axi_l1_V.BVALID  = bvalid_q;
    assign s_axi_l1_V.BRESP   = bresp_q;
    assign s_axi_l1_V.BID     = 1'b0;

`ifdef L1_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (r_hs) rd_cnt_q <= sat_inc(rd_cnt_q);
            if (b_hs) wr_cnt_q <= sat_inc(wr_cnt_q);
            if ((r_hs && err_q[PIPE_TOP]) || (b_hs && (bresp_q == SLVERR)))
                err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign stat_rd_beats = rd_cnt_q;
    assign stat_wr       = wr_cnt_q;
    assign stat_err      = err_cnt_q;
`else
    assign stat_rd_beats = '0;
    assign stat_wr       = '0;
    assign stat_err      = '0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axi_l1_V.ARADDR[1:0], s_axi_l1_V.WLAST, awaddr_q[1:0]};

endmodule
